// File: rtl/i2q2_history.sv
// Squares early/prompt/late correlator dumps with one shared multiplier and keeps
// the previous-epoch prompt and tracking-loop history for the discriminators.
module i2q2_history #(
    parameter int ACC_W = 18,
    parameter int IQ_W  = 18,
    parameter int WDF_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accumulation_complete,
    input  logic signed [ACC_W-1:0]  i_early,
    input  logic signed [ACC_W-1:0]  q_early,
    input  logic signed [ACC_W-1:0]  i_prompt,
    input  logic signed [ACC_W-1:0]  q_prompt,
    input  logic signed [ACC_W-1:0]  i_late,
    input  logic signed [ACC_W-1:0]  q_late,
    input  logic                     tracking_ready,
    input  logic        [IQ_W-1:0]   iq_prompt_k_in,
    input  logic signed [WDF_W-1:0]  w_df_kp1,
    input  logic signed [WDF_W-1:0]  w_df_dot_kp1,
    output logic                     i2q2_valid,
    output logic        [2*ACC_W-1:0] i2q2_early_k,
    output logic        [2*ACC_W-1:0] i2q2_prompt_k,
    output logic        [2*ACC_W-1:0] i2q2_late_k,
    output logic signed [ACC_W-1:0]  i_prompt_k,
    output logic signed [ACC_W-1:0]  q_prompt_k,
    output logic signed [ACC_W-1:0]  i_prompt_km1,
    output logic signed [ACC_W-1:0]  q_prompt_km1,
    output logic        [IQ_W-1:0]   iq_prompt_km1,
    output logic signed [WDF_W-1:0]  w_df_k,
    output logic signed [WDF_W-1:0]  w_df_dot_k,
    output logic                     busy,
    output logic                     overrun,
    output logic                     history_valid
);

    localparam int unsigned SQ_W   = 2 * ACC_W;
    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(5);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SQUARE     = 2'd1,
        WAIT_TRACK = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [STEP_W-1:0] step_q;

    logic signed [ACC_W-1:0] i_e_q, q_e_q, i_l_q, q_l_q;

    logic accept, commit, last_step, overrun_set;
    logic signed [ACC_W-1:0] mul_op;
    logic signed [SQ_W-1:0]  product;
    logic        [SQ_W-1:0]  square;

    // Next-state and control decode; dumps arriving outside IDLE only flag overrun.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        commit      = 1'b0;
        last_step   = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (accumulation_complete) begin
                    accept  = 1'b1;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                overrun_set = accumulation_complete;
                if (step_q == LAST_STEP) begin
                    last_step = 1'b1;
                    state_d   = WAIT_TRACK;
                end
            end
            WAIT_TRACK: begin
                overrun_set = accumulation_complete;
                if (tracking_ready) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared squarer: operand order i_e, q_e, i_p, q_p, i_l, q_l.
    always_comb begin
        mul_op = q_l_q;
        case (step_q)
            3'd0:    mul_op = i_e_q;
            3'd1:    mul_op = q_e_q;
            3'd2:    mul_op = i_prompt_k;
            3'd3:    mul_op = q_prompt_k;
            3'd4:    mul_op = i_l_q;
            default: mul_op = q_l_q;
        endcase
        product = SQ_W'(mul_op) * SQ_W'(mul_op);
        square  = $unsigned(product);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q        <= '0;
            i_e_q         <= '0;
            q_e_q         <= '0;
            i_l_q         <= '0;
            q_l_q         <= '0;
            i2q2_valid    <= 1'b0;
            i2q2_early_k  <= '0;
            i2q2_prompt_k <= '0;
            i2q2_late_k   <= '0;
            i_prompt_k    <= '0;
            q_prompt_k    <= '0;
            i_prompt_km1  <= '0;
            q_prompt_km1  <= '0;
            iq_prompt_km1 <= '0;
            w_df_k        <= '0;
            w_df_dot_k    <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            history_valid <= 1'b0;
        end else begin
            i2q2_valid <= last_step;
            busy       <= (state_d != IDLE);
            if (overrun_set) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                i_e_q         <= i_early;
                q_e_q         <= q_early;
                i_l_q         <= i_late;
                q_l_q         <= q_late;
                i_prompt_km1  <= i_prompt_k;
                q_prompt_km1  <= q_prompt_k;
                i_prompt_k    <= i_prompt;
                q_prompt_k    <= q_prompt;
                i2q2_early_k  <= '0;
                i2q2_prompt_k <= '0;
                i2q2_late_k   <= '0;
                step_q        <= '0;
            end else if (state_q == SQUARE) begin
                case (step_q[2:1])
                    2'd0:    i2q2_early_k  <= i2q2_early_k + square;
                    2'd1:    i2q2_prompt_k <= i2q2_prompt_k + square;
                    default: i2q2_late_k   <= i2q2_late_k + square;
                endcase
                if (!last_step) begin
                    step_q <= step_q + STEP_W'(1);
                end
            end

            if (commit) begin
                iq_prompt_km1 <= iq_prompt_k_in;
                w_df_k        <= w_df_kp1;
                w_df_dot_k    <= w_df_dot_kp1;
                history_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2q2_history.sv
// Directed checks of the I^2+Q^2 squarer/history block: timing, extremes, commit, overrun, reset.
module tb_i2q2_history;

    localparam int ACC_W = 18;
    localparam int IQ_W  = 18;
    localparam int WDF_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic accumulation_complete;
    logic signed [ACC_W-1:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
    logic tracking_ready;
    logic [IQ_W-1:0] iq_prompt_k_in;
    logic signed [WDF_W-1:0] w_df_kp1, w_df_dot_kp1;
    logic i2q2_valid;
    logic [2*ACC_W-1:0] i2q2_early_k, i2q2_prompt_k, i2q2_late_k;
    logic signed [ACC_W-1:0] i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1;
    logic [IQ_W-1:0] iq_prompt_km1;
    logic signed [WDF_W-1:0] w_df_k, w_df_dot_k;
    logic busy, overrun, history_valid;

    int checks = 0;
    int errors = 0;

    i2q2_history #(.ACC_W(ACC_W), .IQ_W(IQ_W), .WDF_W(WDF_W)) dut (
        .clk(clk), .reset(reset), .accumulation_complete(accumulation_complete),
        .i_early(i_early), .q_early(q_early), .i_prompt(i_prompt), .q_prompt(q_prompt),
        .i_late(i_late), .q_late(q_late), .tracking_ready(tracking_ready),
        .iq_prompt_k_in(iq_prompt_k_in), .w_df_kp1(w_df_kp1), .w_df_dot_kp1(w_df_dot_kp1),
        .i2q2_valid(i2q2_valid), .i2q2_early_k(i2q2_early_k), .i2q2_prompt_k(i2q2_prompt_k),
        .i2q2_late_k(i2q2_late_k), .i_prompt_k(i_prompt_k), .q_prompt_k(q_prompt_k),
        .i_prompt_km1(i_prompt_km1), .q_prompt_km1(q_prompt_km1), .iq_prompt_km1(iq_prompt_km1),
        .w_df_k(w_df_k), .w_df_dot_k(w_df_dot_k), .busy(busy), .overrun(overrun),
        .history_valid(history_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dump(input int ie, input int qe, input int ip, input int qp,
                            input int il, input int ql);
        i_early  = ACC_W'(ie);
        q_early  = ACC_W'(qe);
        i_prompt = ACC_W'(ip);
        q_prompt = ACC_W'(qp);
        i_late   = ACC_W'(il);
        q_late   = ACC_W'(ql);
    endtask

    // Pulse the dump strobe for one cycle; returns positioned in cycle 1.
    task automatic strobe_dump(input int ie, input int qe, input int ip, input int qp,
                               input int il, input int ql);
        set_dump(ie, qe, ip, qp, il, ql);
        accumulation_complete = 1'b1;
        tick();
        accumulation_complete = 1'b0;
        set_dump(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_commit(input int iq, input int wdf, input int wdd);
        iq_prompt_k_in = IQ_W'(iq);
        w_df_kp1       = WDF_W'(wdf);
        w_df_dot_kp1   = WDF_W'(wdd);
        tracking_ready = 1'b1;
        tick();
        tracking_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (i2q2_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || history_valid !== 1'b0 ||
            i2q2_early_k !== '0 || i2q2_prompt_k !== '0 || i2q2_late_k !== '0 ||
            i_prompt_k !== '0 || q_prompt_k !== '0 || i_prompt_km1 !== '0 || q_prompt_km1 !== '0 ||
            iq_prompt_km1 !== '0 || w_df_k !== '0 || w_df_dot_k !== '0) begin
            errors++;
            $display("FAIL %s: outputs not all zero (valid=%b busy=%b ovr=%b hv=%b e=%0d p=%0d l=%0d ipk=%0d km1=%0d wdf=%0d)",
                     tag, i2q2_valid, busy, overrun, history_valid, i2q2_early_k, i2q2_prompt_k,
                     i2q2_late_k, i_prompt_k, i_prompt_km1, w_df_k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        accumulation_complete = 1'b0;
        tracking_ready = 1'b0;
        iq_prompt_k_in = '0;
        w_df_kp1 = '0;
        w_df_dot_kp1 = '0;
        set_dump(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all_zero("reset_state");
        // strobe while reset is held must be ignored
        set_dump(9, 9, 9, 9, 9, 9);
        accumulation_complete = 1'b1;
        tick();
        accumulation_complete = 1'b0;
        set_dump(0, 0, 0, 0, 0, 0);
        check_all_zero("reset_override");
        reset = 1'b0;
        tick();
        // tracking_ready in IDLE is ignored
        do_commit(99, 5, 5);
        checks++;
        if (history_valid !== 1'b0 || iq_prompt_km1 !== '0 || w_df_k !== '0) begin
            errors++;
            $display("FAIL track_in_idle: hv=%b iq_km1=%0d wdf=%0d expected 0 0 0",
                     history_valid, iq_prompt_km1, w_df_k);
        end
    endtask

    task automatic test_basic_dump();
        strobe_dump(3, 4, -5, 12, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (busy !== 1'b1 || i2q2_valid !== (c == 7)) begin
                errors++;
                $display("FAIL basic_timing cycle %0d: busy=%b valid=%b expected busy=1 valid=%b",
                         c, busy, i2q2_valid, (c == 7));
            end
            if (c < 7) tick();
        end
        checks++;
        if (i2q2_early_k !== 36'd25 || i2q2_prompt_k !== 36'd169 || i2q2_late_k !== 36'd0) begin
            errors++;
            $display("FAIL basic_values: e=%0d p=%0d l=%0d expected 25 169 0",
                     i2q2_early_k, i2q2_prompt_k, i2q2_late_k);
        end
        checks++;
        if (i_prompt_km1 !== 0 || q_prompt_km1 !== 0 || i_prompt_k !== -5 || q_prompt_k !== 12) begin
            errors++;
            $display("FAIL basic_prompt: ipk=%0d qpk=%0d ikm1=%0d qkm1=%0d expected -5 12 0 0",
                     i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1);
        end
        tick();
        checks++;
        if (i2q2_valid !== 1'b0 || busy !== 1'b1 || i2q2_prompt_k !== 36'd169) begin
            errors++;
            $display("FAIL basic_after: valid=%b busy=%b p=%0d expected 0 1 169",
                     i2q2_valid, busy, i2q2_prompt_k);
        end
    endtask

    task automatic test_commit_history();
        do_commit(13, 100, -7);
        checks++;
        if (iq_prompt_km1 !== 18'd13 || w_df_k !== 100 || w_df_dot_k !== -7 ||
            history_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL commit: iq_km1=%0d wdf=%0d wdd=%0d hv=%b busy=%b expected 13 100 -7 1 0",
                     iq_prompt_km1, w_df_k, w_df_dot_k, history_valid, busy);
        end
        strobe_dump(2, -2, 1, 1, 7, -1);
        checks++;
        if (i_prompt_km1 !== -5 || q_prompt_km1 !== 12) begin
            errors++;
            $display("FAIL history_km1: ikm1=%0d qkm1=%0d expected -5 12", i_prompt_km1, q_prompt_km1);
        end
        repeat (6) tick();
        checks++;
        if (i2q2_valid !== 1'b1 || i2q2_early_k !== 36'd8 || i2q2_prompt_k !== 36'd2 ||
            i2q2_late_k !== 36'd50) begin
            errors++;
            $display("FAIL history_values: valid=%b e=%0d p=%0d l=%0d expected 1 8 2 50",
                     i2q2_valid, i2q2_early_k, i2q2_prompt_k, i2q2_late_k);
        end
        do_commit(1, 5, 6);
    endtask

    task automatic test_extremes();
        strobe_dump(-131072, -131072, -131072, -131072, -131072, -131072);
        repeat (6) tick();
        checks++;
        if (i2q2_valid !== 1'b1 || i2q2_early_k !== 36'd34359738368 ||
            i2q2_prompt_k !== 36'd34359738368 || i2q2_late_k !== 36'd34359738368) begin
            errors++;
            $display("FAIL extremes: valid=%b e=%0d p=%0d l=%0d expected 1 and 34359738368 each",
                     i2q2_valid, i2q2_early_k, i2q2_prompt_k, i2q2_late_k);
        end
        do_commit(2, 3, 4);
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b expected 0", overrun);
        end
        strobe_dump(1, 2, 3, 4, 5, 6);
        tick();
        tick();
        // cycle 3: illegal second dump
        set_dump(7, 7, 7, 7, 7, 7);
        accumulation_complete = 1'b1;
        tick();
        accumulation_complete = 1'b0;
        set_dump(0, 0, 0, 0, 0, 0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        repeat (3) tick();
        checks++;
        if (i2q2_valid !== 1'b1 || i2q2_early_k !== 36'd5 || i2q2_prompt_k !== 36'd25 ||
            i2q2_late_k !== 36'd61 || i_prompt_k !== 3 || q_prompt_k !== 4) begin
            errors++;
            $display("FAIL overrun_values: valid=%b e=%0d p=%0d l=%0d ipk=%0d qpk=%0d expected 1 5 25 61 3 4",
                     i2q2_valid, i2q2_early_k, i2q2_prompt_k, i2q2_late_k, i_prompt_k, q_prompt_k);
        end
        tick();
        // dump coincident with commit: commit wins, dump dropped
        set_dump(9, 9, 9, 9, 9, 9);
        accumulation_complete = 1'b1;
        do_commit(20, -1, -2);
        accumulation_complete = 1'b0;
        set_dump(0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || iq_prompt_km1 !== 18'd20 || w_df_k !== -1 || w_df_dot_k !== -2 ||
            overrun !== 1'b1 || i2q2_prompt_k !== 36'd25 || i_prompt_k !== 3) begin
            errors++;
            $display("FAIL overrun_commit: busy=%b iq_km1=%0d wdf=%0d wdd=%0d ovr=%b p=%0d ipk=%0d expected 0 20 -1 -2 1 25 3",
                     busy, iq_prompt_km1, w_df_k, w_df_dot_k, overrun, i2q2_prompt_k, i_prompt_k);
        end
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (i2q2_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
                errors++;
                $display("FAIL overrun_drop cycle %0d: valid=%b busy=%b ovr=%b expected 0 0 1",
                         c, i2q2_valid, busy, overrun);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        strobe_dump(3, 4, -5, 12, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_mid");
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (i2q2_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet cycle %0d: valid=%b busy=%b expected 0 0",
                         c, i2q2_valid, busy);
            end
            tick();
        end
        strobe_dump(3, 4, -5, 12, 6, 8);
        repeat (6) tick();
        checks++;
        if (i2q2_valid !== 1'b1 || i2q2_early_k !== 36'd25 || i2q2_prompt_k !== 36'd169 ||
            i2q2_late_k !== 36'd100 || i_prompt_km1 !== 0) begin
            errors++;
            $display("FAIL reset_recover: valid=%b e=%0d p=%0d l=%0d ikm1=%0d expected 1 25 169 100 0",
                     i2q2_valid, i2q2_early_k, i2q2_prompt_k, i2q2_late_k, i_prompt_km1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_dump();
        test_commit_history();
        test_extremes();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2q2_history.md
I2Q2_HISTORY -- requirements
Module: i2q2_history

Interface
REQ-001 SHALL have parameter ACC_W, default 18, signed accumulator width.
REQ-002 SHALL have parameter IQ_W, default 18, unsigned |IQ| width.
REQ-003 SHALL have parameter WDF_W, default 16, signed w_df and w_df_dot width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high.
REQ-006 SHALL have port accumulation_complete  in  1  one-cycle dump strobe.
REQ-007 SHALL have ports i_early, q_early, i_prompt, q_prompt, i_late, q_late  in  ACC_W each  signed dump values; valid only with the strobe.
REQ-008 SHALL have port tracking_ready  in  1  one-cycle loop-completion strobe from tracking_loops.
REQ-009 SHALL have ports iq_prompt_k_in  in  IQ_W; w_df_kp1, w_df_dot_kp1  in  WDF_W  loop results, valid with tracking_ready.
REQ-010 SHALL have port i2q2_valid  out  1  one-cycle result strobe.
REQ-011 SHALL have ports i2q2_early_k, i2q2_prompt_k, i2q2_late_k  out  2*ACC_W each  unsigned I^2+Q^2.
REQ-012 SHALL have ports i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1  out  ACC_W; iq_prompt_km1  out  IQ_W; w_df_k, w_df_dot_k  out  WDF_W.
REQ-013 SHALL have ports busy  out  1; overrun  out  1 (sticky); history_valid  out  1.

Function
REQ-014 SHALL implement FSM states IDLE, SQUARE, WAIT_TRACK.
REQ-015 In IDLE, accumulation_complete SHALL:
  - latch all six dump inputs;
  - copy current i_prompt_k/q_prompt_k into the km1 registers;
  - clear the three sum registers;
  - load step counter 0;
  - enter SQUARE.
REQ-016 SQUARE SHALL use a single signed ACC_W x ACC_W multiplier, one square per cycle, in order i_e, q_e, i_p, q_p, i_l, q_l.
  - Each product is added into its sum register.
  - Counter runs 0..5.
  - Exit to WAIT_TRACK after step 5.
REQ-017 Arithmetic SHALL be exact: square of -2^(ACC_W-1) and sum of two such squares fit 2*ACC_W bits unsigned, with no saturation or truncation.
REQ-018 i2q2_valid SHALL pulse exactly one cycle, 7 cycles after the accepted strobe (strobe cycle 0, valid cycle 7).
  - i2q2_* and i/q_prompt_k SHALL be stable from cycle 7 until the next accepted strobe.
REQ-019 In WAIT_TRACK, tracking_ready SHALL:
  - load iq_prompt_km1 <= iq_prompt_k_in, w_df_k <= w_df_kp1, w_df_dot_k <= w_df_dot_kp1;
  - set history_valid;
  - return to IDLE.
REQ-020 tracking_ready outside WAIT_TRACK SHALL be ignored.
REQ-021 accumulation_complete outside IDLE SHALL be dropped, with no register change except setting overrun.
  - This includes the cycle in which tracking_ready is also asserted in WAIT_TRACK: commit proceeds, the dump is dropped, overrun is set.
REQ-022 busy SHALL be high whenever state is not IDLE.
REQ-023 overrun SHALL stay set until reset.
REQ-024 Until history_valid is set, the km1 and w_df outputs SHALL read 0.

Reset
REQ-025 reset SHALL override all other inputs in the same cycle.
REQ-026 On reset, state SHALL be IDLE and counter 0.
REQ-027 On reset, the following outputs SHALL be 0: i2q2_valid, all i2q2_*, all i/q_prompt registers, iq_prompt_km1, w_df_k, w_df_dot_k, busy, overrun, history_valid.
REQ-028 Reset asserted during SQUARE or WAIT_TRACK SHALL abort the operation with no i2q2_valid pulse.
  - The first strobe after reset deassertion SHALL be accepted normally.

Verification
REQ-029 Basic dump: strobe with i_e=3, q_e=4, i_p=-5, q_p=12, i_l=0, q_l=0 -> at cycle 7, i2q2_valid=1 for one cycle; early=25, prompt=169, late=0; i_prompt_km1=q_prompt_km1=0; busy=1 cycles 1..7.
REQ-030 Extremes: all inputs -131072 -> at cycle 7, all three i2q2 = 34359738368 (2^35), exact.
REQ-031 Commit and history:
  - After REQ-029, drive tracking_ready with iq_prompt_k_in=13, w_df_kp1=100, w_df_dot_kp1=-7 -> next cycle iq_prompt_km1=13, w_df_k=100, w_df_dot_k=-7, history_valid=1, busy=0.
  - Next dump with i_p=1, q_p=1 -> i_prompt_km1=-5, q_prompt_km1=12, prompt=2.
REQ-032 Overrun:
  - Strobe at cycle 3 after an accepted dump -> results unchanged from the first dump, overrun=1 and remains set.
  - Strobe coincident with tracking_ready -> commit occurs, no new i2q2_valid, overrun=1.
REQ-033 Reset mid-operation: reset at cycle 4 of SQUARE -> no i2q2_valid, all outputs 0; next strobe yields valid results at +7 cycles.
